// File: rtl/spi_frame_tx.sv
// SPI master transmitter: serialises a NUM_CH x DATA_W frame under one slave-select window,
// with a one-frame holding buffer so the next frame can be queued while the current one shifts.
module spi_frame_tx #(
    parameter int DATA_W    = 16,
    parameter int NUM_CH    = 2,
    parameter int CLK_DIV   = 4,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int MSB_FIRST = 1,
    parameter int SS_GAP    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     spi_sck,
    output logic                     spi_mosi,
    output logic                     spi_ss_n,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int TOTAL    = NUM_CH * DATA_W;
    localparam int HP_SHIFT = 2 * TOTAL;
    localparam int HPW      = $clog2(HP_SHIFT + SS_GAP + 1);
    localparam int CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [HPW-1:0] HP_SHIFT_LAST = HPW'(HP_SHIFT - 1);
    localparam logic [HPW-1:0] GAP_LAST      = HPW'(SS_GAP - 1);
    localparam logic [CW-1:0]  CNT_LAST      = CW'(CLK_DIV - 1);
    localparam logic           SCK_IDLE      = (CPOL != 0);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LEAD  = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] TRAIL = 3'd3;
    localparam logic [2:0] GAP   = 3'd4;

    logic [2:0]       state;
    logic [CW-1:0]    cnt;
    logic [HPW-1:0]   hp;
    logic             sck_q;
    logic             mosi_q;
    logic [TOTAL-1:0] shreg;
    logic [TOTAL-1:0] buf_q;
    logic             buf_full;

    logic [TOTAL-1:0] tx_vec;
    logic [TOTAL-1:0] load_shreg;
    logic             first_mosi;
    logic             tick;
    logic             active;
    logic             present;

    // Handshake: a frame moves into buf_q on any edge with in_valid && in_ready;
    // in_ready is simply "buffer empty", so a drain cycle never accepts.
    assign in_ready = !buf_full;
    assign busy     = (state != IDLE) || buf_full;

    assign tick   = (state != IDLE) && (cnt == CNT_LAST);
    assign active = (state == LEAD) || (state == SHIFT) || (state == TRAIL);

    // tx_vec always holds the first bit to send in its top position.
    always_comb begin
        tx_vec = buf_q;
        if (MSB_FIRST == 0) begin
            for (int w = 0; w < NUM_CH; w++) begin
                for (int b = 0; b < DATA_W; b++) begin
                    tx_vec[w*DATA_W + b] = buf_q[w*DATA_W + DATA_W - 1 - b];
                end
            end
        end
    end

    assign load_shreg = (CPHA == 0) ? (tx_vec << 1) : tx_vec;
    assign first_mosi = (CPHA == 0) ? tx_vec[TOTAL-1] : 1'b0;

    // hp counts SCK edges in SHIFT: even = leading, odd = trailing.
    assign present = (CPHA != 0) ? !hp[0] : (hp[0] && (hp != HP_SHIFT_LAST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            hp         <= '0;
            sck_q      <= SCK_IDLE;
            mosi_q     <= 1'b0;
            shreg      <= '0;
            buf_q      <= '0;
            buf_full   <= 1'b0;
            spi_sck    <= SCK_IDLE;
            spi_mosi   <= 1'b0;
            spi_ss_n   <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            // Pin stage: one registered copy of the internal line state.
            spi_sck    <= sck_q;
            spi_ss_n   <= !active;
            spi_mosi   <= active && mosi_q;
            frame_done <= !spi_ss_n && !active;

            if (in_valid && !buf_full) begin
                buf_q    <= in_data;
                buf_full <= 1'b1;
            end

            if (state == IDLE || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (buf_full) begin
                        state    <= LEAD;
                        buf_full <= 1'b0;
                        cnt      <= '0;
                        hp       <= '0;
                        shreg    <= load_shreg;
                        mosi_q   <= first_mosi;
                    end
                end
                LEAD: begin
                    if (tick) begin
                        state <= SHIFT;
                        hp    <= '0;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        sck_q <= ~sck_q;
                        if (present) begin
                            mosi_q <= shreg[TOTAL-1];
                            shreg  <= shreg << 1;
                        end
                        if (hp == HP_SHIFT_LAST) begin
                            state <= TRAIL;
                            hp    <= '0;
                        end else begin
                            hp <= hp + 1'b1;
                        end
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        state  <= GAP;
                        mosi_q <= 1'b0;
                        hp     <= '0;
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (hp == GAP_LAST) begin
                            hp <= '0;
                            if (buf_full) begin
                                state    <= LEAD;
                                buf_full <= 1'b0;
                                cnt      <= '0;
                                shreg    <= load_shreg;
                                mosi_q   <= first_mosi;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            hp <= hp + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_tx.sv
// Bench for spi_frame_tx: three configurations driven with directed and random frames,
// a line monitor that rebuilds each frame from sampled SCK edges, and a frame scoreboard.
module tb_spi_frame_tx;

    int cfg_dw[3]   = '{16, 16, 8};
    int cfg_nch[3]  = '{2, 2, 3};
    int cfg_div[3]  = '{4, 1, 2};
    int cfg_cpol[3] = '{0, 1, 1};
    int cfg_cpha[3] = '{0, 1, 0};
    int cfg_msb[3]  = '{1, 1, 0};
    int cfg_gap[3]  = '{2, 2, 3};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] din [3];
    logic [2:0]  vld, rdy, sck, mosi, ss, busy, done;

    int checks = 0;
    int errors = 0;

    int          neg_cnt = 0;
    logic        prev_ss [3];
    logic        prev_sck [3];
    logic        acc_pending [3];
    logic [63:0] cap [3];
    logic [63:0] last_cap [3];
    int ncap [3], sslow [3], hi_cnt [3], last_gap [3], last_fall [3], last_period [3];
    int frames [3], dones [3], accs [3], acc_neg [3], lat [3], gap_edges [3], mosi_bad [3];
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    spi_frame_tx #(.DATA_W(16), .NUM_CH(2), .CLK_DIV(4), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SS_GAP(2)) dut0 (
        .clk(clk), .rst(rst), .in_data(din[0][31:0]), .in_valid(vld[0]), .in_ready(rdy[0]),
        .spi_sck(sck[0]), .spi_mosi(mosi[0]), .spi_ss_n(ss[0]), .busy(busy[0]), .frame_done(done[0]));

    spi_frame_tx #(.DATA_W(16), .NUM_CH(2), .CLK_DIV(1), .CPOL(1), .CPHA(1), .MSB_FIRST(1), .SS_GAP(2)) dut1 (
        .clk(clk), .rst(rst), .in_data(din[1][31:0]), .in_valid(vld[1]), .in_ready(rdy[1]),
        .spi_sck(sck[1]), .spi_mosi(mosi[1]), .spi_ss_n(ss[1]), .busy(busy[1]), .frame_done(done[1]));

    spi_frame_tx #(.DATA_W(8), .NUM_CH(3), .CLK_DIV(2), .CPOL(1), .CPHA(0), .MSB_FIRST(0), .SS_GAP(3)) dut2 (
        .clk(clk), .rst(rst), .in_data(din[2][23:0]), .in_valid(vld[2]), .in_ready(rdy[2]),
        .spi_sck(sck[2]), .spi_mosi(mosi[2]), .spi_ss_n(ss[2]), .busy(busy[2]), .frame_done(done[2]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference bit stream: first transmitted bit ends up in the most significant used position.
    function automatic logic [63:0] model(input int i, input logic [63:0] d);
        logic [63:0] s;
        logic [63:0] w;
        int idx;
        s = '0;
        for (int ch = 0; ch < cfg_nch[i]; ch++) begin
            w = d >> ((cfg_nch[i] - 1 - ch) * cfg_dw[i]);
            for (int b = 0; b < cfg_dw[i]; b++) begin
                idx = (cfg_msb[i] != 0) ? (cfg_dw[i] - 1 - b) : b;
                s = (s << 1) | {63'b0, w[idx]};
            end
        end
        return s;
    endfunction

    function automatic logic samp_lvl(input int i);
        return (cfg_cpol[i] == cfg_cpha[i]);
    endfunction

    task automatic frame_end(input int i);
        int t;
        logic [63:0] e;
        t = cfg_nch[i] * cfg_dw[i];
        check("sb_has_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("frame_bits", cap[i], e);
        end
        check("frame_nbits", ncap[i], t);
        check("ss_low_len", sslow[i], cfg_div[i] * (2 + 2 * t));
        check("done_at_ss_rise", done[i], 1);
        last_cap[i] = cap[i];
        frames[i]++;
    endtask

    always @(negedge clk) begin
        neg_cnt++;
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                exp_q.delete();
                ncap[i] = 0;
                cap[i] = '0;
                acc_pending[i] = 1'b0;
                prev_ss[i] = ss[i];
                prev_sck[i] = sck[i];
            end else begin
                if (acc_pending[i]) begin
                    acc_neg[i] = neg_cnt;
                    acc_pending[i] = 1'b0;
                end
                if (vld[i] && rdy[i]) begin
                    exp_q.push_back(model(i, din[i]));
                    accs[i]++;
                    acc_pending[i] = 1'b1;
                end
                if (done[i]) dones[i]++;
                if (ss[i] && mosi[i]) mosi_bad[i]++;
                if (!ss[i] && prev_ss[i]) begin
                    last_period[i] = neg_cnt - last_fall[i];
                    last_fall[i] = neg_cnt;
                    last_gap[i] = hi_cnt[i];
                    lat[i] = neg_cnt - acc_neg[i];
                    cap[i] = '0;
                    ncap[i] = 0;
                    sslow[i] = 0;
                end
                if (ss[i] && !prev_ss[i]) begin
                    frame_end(i);
                    hi_cnt[i] = 0;
                end
                if (ss[i]) hi_cnt[i]++;
                else sslow[i]++;
                if (sck[i] != prev_sck[i]) begin
                    if (ss[i]) gap_edges[i]++;
                    else if (sck[i] == samp_lvl(i)) begin
                        cap[i] = (cap[i] << 1) | {63'b0, mosi[i]};
                        ncap[i]++;
                    end
                end
                prev_ss[i] = ss[i];
                prev_sck[i] = sck[i];
            end
        end
    end

    task automatic offer(input int i, input logic [63:0] d, output int waited);
        int n;
        @(posedge clk); #1;
        din[i] = d;
        vld[i] = 1'b1;
        for (n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (rdy[i]) break;
        end
        check("offer_accepted", n < 2000, 1);
        @(posedge clk); #1;
        vld[i] = 1'b0;
        waited = n;
    endtask

    task automatic wait_frames(input int i, input int target);
        for (int n = 0; n < 5000 && frames[i] < target; n++) @(negedge clk);
        @(negedge clk);
        check("frame_count_reached", frames[i] >= target, 1);
    endtask

    task automatic chk_idle(input int i);
        check("idle_sck", sck[i], cfg_cpol[i]);
        check("idle_mosi", mosi[i], 0);
        check("idle_ss_n", ss[i], 1);
        check("idle_ready", rdy[i], 1);
        check("idle_busy", busy[i], 0);
        check("idle_done", done[i], 0);
    endtask

    initial begin
        int w, n, f, a, d;
        for (int i = 0; i < 3; i++) begin
            prev_ss[i] = 1'b1;
            prev_sck[i] = 1'(cfg_cpol[i]);
            din[i] = '0;
        end
        vld = '0;

        // Reset values
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_idle(i);
        #1 rst = 1'b1;

        // Mode 0, defaults, known word
        offer(0, 64'hA5C3_0F01, w);
        wait_frames(0, 1);
        check("t1_accept_to_ss_low", lat[0], 2);
        check("t1_stream", last_cap[0], 64'hA5C3_0F01);
        check("t1_done_count", dones[0], 1);

        // CPOL=1 CPHA=1 CLK_DIV=1
        offer(1, 64'h8000_0001, w);
        wait_frames(1, 1);
        check("t2_stream", last_cap[1], 64'h8000_0001);
        check("t2_sck_idles_high", sck[1], 1);

        // LSB first, three 8-bit channels
        offer(2, 64'h0001_80F0, w);
        wait_frames(2, 1);
        check("t3_stream", last_cap[2], 64'h0080_010F);

        // Back-to-back with back-pressure
        f = frames[0];
        offer(0, {$urandom, $urandom}, w);
        repeat (20) @(negedge clk);
        check("t4_first_in_shift", ss[0], 0);
        offer(0, {$urandom, $urandom}, w);
        check("t4_second_immediate", w, 0);
        check("t4_ready_low_when_full", rdy[0], 0);
        offer(0, {$urandom, $urandom}, w);
        check("t4_third_backpressured", w > 0, 1);
        wait_frames(0, f + 3);
        check("t4_gap_cycles", last_gap[0], cfg_gap[0] * cfg_div[0]);
        check("t4_period", last_period[0], 272);

        // in_valid held high for four accepts
        f = frames[0];
        a = accs[0];
        @(posedge clk); #1;
        din[0] = {$urandom, $urandom};
        vld[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (n = 0; n < 2000; n++) begin
                @(negedge clk);
                if (rdy[0]) break;
            end
            check("t5_accept_bound", n < 2000, 1);
            @(posedge clk); #1;
            din[0] = {$urandom, $urandom};
        end
        vld[0] = 1'b0;
        wait_frames(0, f + 4);
        check("t5_accepts", accs[0] - a, 4);
        check("t5_frames", frames[0] - f, 4);
        check("t5_period", last_period[0], 272);
        check("t5_sb_drained", exp_q.size(), 0);

        // Random frames on every configuration
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) begin
                f = frames[i];
                offer(i, {$urandom, $urandom}, w);
                wait_frames(i, f + 1);
            end
        end

        // Reset in the middle of a frame
        offer(0, {$urandom, $urandom}, w);
        for (n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (!ss[0] && ncap[0] >= 10) break;
        end
        check("t7_reached_bit10", n < 2000, 1);
        d = dones[0];
        f = frames[0];
        #2 rst = 1'b0;
        #1;
        chk_idle(0);
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        repeat (400) @(negedge clk);
        check("t7_no_done", dones[0], d);
        check("t7_no_frame", frames[0], f);
        check("t7_buffer_lost", exp_q.size(), 0);
        offer(0, {$urandom, $urandom}, w);
        wait_frames(0, f + 1);

        for (int i = 0; i < 3; i++) begin
            check("no_sck_edge_in_gap", gap_edges[i], 0);
            check("mosi_low_when_ss_high", mosi_bad[i], 0);
            check("done_count_matches", dones[i], frames[i]);
        end
        check("sb_empty_at_end", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
